// File: rtl/dsm_dac.sv
// dsm_dac: first-order delta-sigma DAC modulator.
// Takes WIDTH-bit offset-binary samples over a valid/ready handshake. Each
// sample is held for OSR clocks. One bitstream bit comes out per clock.
// Build option DSM_DITHER_EN: when defined, an LFSR adds +/-1 LSB dither to
// the accumulator operand. When undefined, the plain modulator is built.
module dsm_dac #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned OSR   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out,
  output logic             frame,
  output logic             underrun,
  input  logic             underrun_clr
);

  localparam int unsigned     CW       = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(OSR - 1);
  localparam logic [WIDTH-1:0] MID     = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             frame_q, frame_d;
  logic             underrun_q, underrun_d;

  logic             boundary;
  logic             accept;
  logic [WIDTH:0]   u;
  logic [WIDTH:0]   sum;

  assign boundary = (cnt_q == CNT_LAST);
  // in_ready depends only on registered state, so there is no path from in_valid.
  assign in_ready = !hold_full_q || boundary;
  assign accept   = in_valid && in_ready;

`ifdef DSM_DITHER_EN
  logic [15:0]      lfsr_q, lfsr_d;
  logic [WIDTH+1:0] u_ext;

  // Fibonacci LFSR, taps 16,14,13,11, advancing every cycle
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register, restarts from its seed on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  // Dithered operand, clamped so the dither can never wrap a full-scale sample
  always_comb begin
    u_ext = {2'b00, active_q}
          + {{(WIDTH+1){1'b0}}, lfsr_q[0]}
          - {{(WIDTH+1){1'b0}}, lfsr_q[1]};
    if (u_ext[WIDTH+1])  u = '0;
    else if (u_ext[WIDTH]) u = {1'b0, {WIDTH{1'b1}}};
    else                 u = {1'b0, u_ext[WIDTH-1:0]};
  end
`else
  assign u = {1'b0, active_q};
`endif

  assign sum = {1'b0, acc_q} + u;

  // Next state: the accumulator carry is the output bit, and samples move hold -> active at the boundary
  always_comb begin
    acc_d       = sum[WIDTH-1:0];
    out_d       = sum[WIDTH];
    frame_d     = boundary;
    cnt_d       = boundary ? '0 : cnt_q + CW'(1);
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
    underrun_d  = underrun_q;
    if (underrun_clr) underrun_d = 1'b0;
    if (boundary) begin
      if (hold_full_q) begin
        active_d    = hold_q;
        hold_full_d = 1'b0;
      end else begin
        underrun_d  = 1'b1;
      end
    end
    // An accept on the boundary cycle refills the slot that was just emptied
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
  end

  // State registers; an asynchronous reset discards any buffered sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      active_q    <= MID;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      frame_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      frame_q     <= frame_d;
      underrun_q  <= underrun_d;
    end
  end

  assign out      = out_q;
  assign frame    = frame_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_dsm_dac.sv
// Self-checking bench for dsm_dac with WIDTH=20 and OSR=15, in the default build without dither.
// Edge k is the k-th rising edge after reset release, with k=0 being the first.
// Outputs are sampled on the falling edge that follows.
module tb_dsm_dac;

  localparam int W = 20;
  localparam int N = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         underrun_clr = 1'b0;
  logic         in_ready, out, frame, underrun;

  int checks = 0;
  int errors = 0;

  bit hist [0:4199];
  int urun_seen, rdy_bad, frm_bad;

  typedef struct {
    logic         vld;
    logic [W-1:0] data;
    logic         clr;
    logic         e_out;
    logic         e_frame;
    logic         e_urun;
    logic         e_ready;
  } vec_t;
  vec_t tbl [45];

  dsm_dac #(.WIDTH(W), .OSR(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out          (out),
    .frame        (frame),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    underrun_clr = 1'b0;
    #1;
    chk("rst.out", 32'(out), 32'd0);
    chk("rst.frame", 32'(frame), 32'd0);
    chk("rst.underrun", 32'(underrun), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Stream a constant sample with in_valid held high and record out per edge
  task automatic capture(input logic [W-1:0] d, input int n);
    apply_reset();
    urun_seen = 0;
    rdy_bad = 0;
    frm_bad = 0;
    in_valid = 1'b1;
    in_data = d;
    for (int k = 0; k < n; k++) begin
      tick();
      hist[k] = out;
      if (underrun) urun_seen++;
      if (in_ready !== ((k % N) == N - 2)) rdy_bad++;
      if (frame !== ((k % N) == N - 1)) frm_bad++;
    end
    in_valid = 1'b0;
  endtask

  function automatic int ones(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) c += int'(hist[k]);
    return c;
  endfunction

  initial begin
    // With no samples, underrun_clr is pulsed at edges 20, 43 and 44.
    // Edge 44 is a boundary with an empty buffer, so the set wins there.
    for (int k = 0; k < 45; k++) begin
      tbl[k].vld     = 1'b0;
      tbl[k].data    = '0;
      tbl[k].clr     = (k == 20) || (k == 43) || (k == 44);
      tbl[k].e_out   = (k % 2) == 1;
      tbl[k].e_frame = (k % N) == N - 1;
      tbl[k].e_urun  = (k >= 14) && !(k >= 20 && k <= 28) && (k != 43);
      tbl[k].e_ready = 1'b1;
    end

    // Idle mid-scale behaviour, frame timing and underrun set/clear
    apply_reset();
    for (int k = 0; k < 45; k++) begin
      in_valid = tbl[k].vld;
      in_data = tbl[k].data;
      underrun_clr = tbl[k].clr;
      tick();
      chk($sformatf("tbl[%0d].out", k), 32'(out), 32'(tbl[k].e_out));
      chk($sformatf("tbl[%0d].frame", k), 32'(frame), 32'(tbl[k].e_frame));
      chk($sformatf("tbl[%0d].underrun", k), 32'(underrun), 32'(tbl[k].e_urun));
      chk($sformatf("tbl[%0d].in_ready", k), 32'(in_ready), 32'(tbl[k].e_ready));
    end
    underrun_clr = 1'b0;

    // Zero stream: the mid-scale pattern ends at edge 14, then out stays 0
    capture(20'h00000, 75);
    chk("zero.pre13", 32'(hist[13]), 32'd1);
    chk("zero.edge14", 32'(hist[14]), 32'd0);
    chk("zero.ones", 32'(ones(15, 74)), 32'd0);
    chk("zero.underrun", 32'(urun_seen), 32'd0);
    chk("zero.ready_pattern", 32'(rdy_bad), 32'd0);
    chk("zero.frame_pattern", 32'(frm_bad), 32'd0);

    // Full-scale stream: acc starts at 2^19 and steps down by 1, so every bit in the window is 1
    capture(20'hFFFFF, 4111);
    chk("full.ones4096", 32'(ones(15, 4110)), 32'd4096);
    chk("full.underrun", 32'(urun_seen), 32'd0);

    // Quarter-scale stream: bits 0,1,0,0,0,1,... from edge 15, i.e. 1 where k%4==0
    capture(20'h40000, 4111);
    chk("quarter.ones4096", 32'(ones(15, 4110)), 32'd1024);
    begin
      int bad = 0;
      for (int k = 15; k <= 4110; k++)
        if (hist[k] != ((k % 4) == 0)) bad++;
      chk("quarter.pattern", 32'(bad), 32'd0);
    end
    chk("quarter.underrun", 32'(urun_seen), 32'd0);

    // Sample offered on the boundary while hold is full: A=0, then B=full scale
    apply_reset();
    in_valid = 1'b1;
    in_data = 20'h00000;
    tick();
    in_valid = 1'b0;
    chk("bnd.ready_after_load", 32'(in_ready), 32'd0);
    for (int k = 1; k <= 13; k++) tick();
    chk("bnd.ready_at_B", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data = 20'hFFFFF;
    tick();
    in_valid = 1'b0;
    chk("bnd.ready_after_B", 32'(in_ready), 32'd0);
    chk("bnd.frame14", 32'(frame), 32'd1);
    begin
      int bad = 0;
      for (int k = 15; k <= 50; k++) begin
        tick();
        if (out !== (k >= 30)) bad++;
        if (k == 29) begin
          chk("bnd.underrun29", 32'(underrun), 32'd0);
          chk("bnd.ready29", 32'(in_ready), 32'd1);
        end
        if (k == 43) chk("bnd.underrun43", 32'(underrun), 32'd0);
        if (k == 44) chk("bnd.underrun44", 32'(underrun), 32'd1);
      end
      chk("bnd.out_sequence", 32'(bad), 32'd0);
    end

    // Reset mid-frame with a full buffer: the held sample must be discarded
    apply_reset();
    in_valid = 1'b1;
    in_data = 20'hFFFFF;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    chk("mid.out_before", 32'(out), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid.async_out", 32'(out), 32'd0);
    chk("mid.async_frame", 32'(frame), 32'd0);
    chk("mid.async_underrun", 32'(underrun), 32'd0);
    chk("mid.async_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    begin
      int bad = 0;
      for (int k = 0; k <= 30; k++) begin
        underrun_clr = (k == 29);
        tick();
        if (out !== ((k % 2) == 1)) bad++;
        if (k == 13) chk("mid.underrun13", 32'(underrun), 32'd0);
        if (k == 14) chk("mid.underrun14", 32'(underrun), 32'd1);
        if (k == 29) chk("mid.clr_vs_set", 32'(underrun), 32'd1);
      end
      underrun_clr = 1'b0;
      chk("mid.out_sequence", 32'(bad), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
